// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer-code helpers for the dual-clock FIFO.
// Contents:
//   ADDR_W        pointer width including the wrap bit
//   DEPTH         RAM depth, 2^(ADDR_W-1)
//   AE_THRESH_DFLT default almost-empty threshold (read side)
//   AF_THRESH     almost-full threshold (write side)
//   bin2gray / gray2bin  32-bit helpers; callers zero-extend narrower pointers,
//                        which is exact for both conversions.
package async_fifo_pkg;

  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned DEPTH          = 1 << (ADDR_W - 1);
  localparam int unsigned AE_THRESH_DFLT = 4;
  localparam int unsigned AF_THRESH      = DEPTH - 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk_i  destination-domain clock
//   rst_i  synchronous active-high reset, clears both stages
//   d_i    pointer from the source domain
//   q_o    pointer after two destination-domain flops
module ptr_sync_2ff #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/async_fifo_read_block.sv
// Read-domain pointer and flag logic of the dual-clock FIFO.
// Optional feature: define ASYNC_FIFO_SYNC_IN_EN to pass the raw write Gray
// pointer rq2 through an internal two-flop synchronizer (empty-deassert
// latency 3 edges); otherwise rq2 is taken as already synchronized (1 edge).
// Ports:
//   rclk, rrst    read clock, synchronous active-high reset
//   r_en          read request from the consumer
//   rq2           write Gray pointer seen in the read domain
//   rgray, rptr   registered Gray / binary read pointer
//   rq2_bin       binary form of the (synchronized) write pointer
//   raddr         RAM read address
//   rcount        entries held, rq2_bin - rptr
//   r_empty       registered empty flag
//   almost_empty  entry count at or below AE_THRESH (always set while empty)
//   under_flow    read requested while empty
//   r_valid       RAM read data valid, one cycle after an accepted read
module async_fifo_read_block
  import async_fifo_pkg::*;
#(
  parameter int unsigned data      = 6,
  parameter int unsigned addr      = ADDR_W,
  parameter int unsigned AE_THRESH = AE_THRESH_DFLT
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            r_en,
  input  logic [addr-1:0] rq2,
  output logic [addr-1:0] rgray,
  output logic [addr-1:0] rptr,
  output logic [addr-1:0] rq2_bin,
  output logic [addr-2:0] raddr,
  output logic [addr-1:0] rcount,
  output logic            r_empty,
  output logic            almost_empty,
  output logic            under_flow,
  output logic            r_valid
);

  // Word width is only carried for interface symmetry with the write side.
  typedef logic [data-1:0] data_word_t;

  localparam logic [addr-1:0] PtrOne  = 1;
  localparam logic [addr-2:0] AddrOne = 1;

  logic [addr-1:0] rptr_q, rptr_d;
  logic [addr-1:0] rgray_q, rgray_d;
  logic [addr-2:0] raddr_q, raddr_d;
  logic            r_empty_q, r_empty_d;
  logic            r_valid_q;
  logic [addr-1:0] rq2_s;
  logic            rd_ok;

`ifdef ASYNC_FIFO_SYNC_IN_EN
  ptr_sync_2ff #(
    .Width (addr)
  ) u_rq2_sync (
    .clk_i (rclk),
    .rst_i (rrst),
    .d_i   (rq2),
    .q_o   (rq2_s)
  );
`else
  assign rq2_s = rq2;
`endif

  always_comb begin
    rd_ok     = r_en && !r_empty_q;
    rptr_d    = rd_ok ? rptr_q + PtrOne : rptr_q;
    raddr_d   = rd_ok ? raddr_q + AddrOne : raddr_q;
    // Gray is computed from the next binary value so the registered Gray
    // pointer only ever changes one bit per edge.
    rgray_d   = addr'(bin2gray(32'(rptr_d)));
    // Full-width compare, wrap bit included: a full FIFO never looks empty.
    r_empty_d = (rgray_d == rq2_s);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_q    <= '0;
      rgray_q   <= '0;
      raddr_q   <= '0;
      r_empty_q <= 1'b1;
      r_valid_q <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      rgray_q   <= rgray_d;
      raddr_q   <= raddr_d;
      r_empty_q <= r_empty_d;
      r_valid_q <= rd_ok;
    end
  end

  always_comb begin
    rq2_bin      = addr'(gray2bin(32'(rq2_s)));
    rcount       = rq2_bin - rptr_q;
    // OR with the registered flag keeps the flag set during the cycle where
    // rq2 has moved but r_empty has not yet caught up.
    almost_empty = r_empty_q || (32'(rcount) <= AE_THRESH);
    under_flow   = r_en && r_empty_q;
  end

  assign rptr    = rptr_q;
  assign rgray   = rgray_q;
  assign raddr   = raddr_q;
  assign r_empty = r_empty_q;
  assign r_valid = r_valid_q;

endmodule

// File: tb/tb_async_fifo_read_block.sv
module tb_async_fifo_read_block;

  logic       rclk;
  logic       rrst;
  logic       r_en;
  logic [5:0] rq2;
  logic [5:0] rgray;
  logic [5:0] rptr;
  logic [5:0] rq2_bin;
  logic [4:0] raddr;
  logic [5:0] rcount;
  logic       r_empty;
  logic       almost_empty;
  logic       under_flow;
  logic       r_valid;

  int checks = 0;
  int errors = 0;

  async_fifo_read_block #(
    .data      (6),
    .addr      (6),
    .AE_THRESH (4)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .r_en         (r_en),
    .rq2          (rq2),
    .rgray        (rgray),
    .rptr         (rptr),
    .rq2_bin      (rq2_bin),
    .raddr        (raddr),
    .rcount       (rcount),
    .r_empty      (r_empty),
    .almost_empty (almost_empty),
    .under_flow   (under_flow),
    .r_valid      (r_valid)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

`ifdef ASYNC_FIFO_SYNC_IN_EN
  localparam int ExpLat = 3;
`else
  localparam int ExpLat = 1;
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] q;
    logic       exp_uf;    // checked before the edge
    logic [5:0] exp_rptr;  // remaining fields checked after the edge
    logic [5:0] exp_rgray;
    logic [4:0] exp_raddr;
    logic       exp_empty;
    logic       exp_valid;
    logic [5:0] exp_count;
    logic [5:0] exp_q2b;
    logic       exp_ae;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic [5:0] q);
    @(negedge rclk);
    rrst = rst;
    r_en = en;
    rq2  = q;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge rclk);
    #1;
  endtask

  // Reset for two edges with rq2 = q, release, and wait (bounded) for the
  // empty flag to reflect q.
  task automatic reset_with(input logic [5:0] q);
    drive(1'b1, 1'b0, q);
    edge_sample();
    edge_sample();
    drive(1'b0, 1'b0, q);
    for (int n = 0; n < 8; n++) begin
      edge_sample();
      if (!r_empty) break;
    end
    chk("reset_with_nonempty", {31'b0, r_empty}, 32'd0);
  endtask

  initial begin
    rrst = 1'b1;
    r_en = 1'b0;
    rq2  = '0;

    //          rst   en    q          uf    rptr       rgray      raddr     e     v     cnt        q2b        ae
    vecs[0] = '{1'b1, 1'b0, 6'b000000, 1'b0, 6'd0,      6'b000000, 5'd0,     1'b1, 1'b0, 6'd0,      6'd0,      1'b1};
    vecs[1] = '{1'b1, 1'b0, 6'b000000, 1'b0, 6'd0,      6'b000000, 5'd0,     1'b1, 1'b0, 6'd0,      6'd0,      1'b1};
    vecs[2] = '{1'b0, 1'b0, 6'b000001, 1'b0, 6'd0,      6'b000000, 5'd0,     1'b0, 1'b0, 6'd1,      6'd1,      1'b1};
    vecs[3] = '{1'b0, 1'b1, 6'b000001, 1'b0, 6'd1,      6'b000001, 5'd1,     1'b1, 1'b1, 6'd0,      6'd1,      1'b1};
    vecs[4] = '{1'b0, 1'b1, 6'b000001, 1'b1, 6'd1,      6'b000001, 5'd1,     1'b1, 1'b0, 6'd0,      6'd1,      1'b1};
    vecs[5] = '{1'b0, 1'b0, 6'b000001, 1'b0, 6'd1,      6'b000001, 5'd1,     1'b1, 1'b0, 6'd0,      6'd1,      1'b1};
    vecs[6] = '{1'b1, 1'b0, 6'b110000, 1'b0, 6'd0,      6'b000000, 5'd0,     1'b1, 1'b0, 6'd32,     6'd32,     1'b1};
    vecs[7] = '{1'b0, 1'b0, 6'b110000, 1'b0, 6'd0,      6'b000000, 5'd0,     1'b0, 1'b0, 6'd32,     6'd32,     1'b0};
    vecs[8] = '{1'b0, 1'b1, 6'b110000, 1'b0, 6'd1,      6'b000001, 5'd1,     1'b0, 1'b1, 6'd31,     6'd32,     1'b0};

`ifndef ASYNC_FIFO_SYNC_IN_EN
    // Vectors assume rq2 is used directly (1-edge empty latency).
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].q);
      // Before the first reset edge the empty flag is unknown.
      if (i > 0) chk($sformatf("v%0d_under_flow", i), {31'b0, under_flow}, {31'b0, vecs[i].exp_uf});
      edge_sample();
      chk($sformatf("v%0d_rptr", i), {26'b0, rptr}, {26'b0, vecs[i].exp_rptr});
      chk($sformatf("v%0d_rgray", i), {26'b0, rgray}, {26'b0, vecs[i].exp_rgray});
      chk($sformatf("v%0d_raddr", i), {27'b0, raddr}, {27'b0, vecs[i].exp_raddr});
      chk($sformatf("v%0d_r_empty", i), {31'b0, r_empty}, {31'b0, vecs[i].exp_empty});
      chk($sformatf("v%0d_r_valid", i), {31'b0, r_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_rcount", i), {26'b0, rcount}, {26'b0, vecs[i].exp_count});
      chk($sformatf("v%0d_rq2_bin", i), {26'b0, rq2_bin}, {26'b0, vecs[i].exp_q2b});
      chk($sformatf("v%0d_almost_empty", i), {31'b0, almost_empty}, {31'b0, vecs[i].exp_ae});
    end
`endif

    // Empty-deassert latency after rq2 steps 0 -> 1.
    drive(1'b1, 1'b0, 6'b000000);
    edge_sample();
    edge_sample();
    drive(1'b0, 1'b0, 6'b000000);
    edge_sample();
    edge_sample();
    edge_sample();
    chk("lat_still_empty", {31'b0, r_empty}, 32'd1);
    drive(1'b0, 1'b0, 6'b000001);
    begin
      int lat;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        edge_sample();
        if (!r_empty) begin
          lat = n;
          break;
        end
      end
      chk("empty_deassert_latency", lat, ExpLat);
    end

    // Full FIFO (write pointer 32) drained by 32 back-to-back reads.
    reset_with(6'b110000);
    chk("full_rcount", {26'b0, rcount}, 32'd32);
    chk("full_almost_empty", {31'b0, almost_empty}, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      drive(1'b0, 1'b1, 6'b110000);
      edge_sample();
      chk($sformatf("drain%0d_rptr", k), {26'b0, rptr}, k);
      chk($sformatf("drain%0d_raddr", k), {27'b0, raddr}, k % 32);
      chk($sformatf("drain%0d_rcount", k), {26'b0, rcount}, 32 - k);
      chk($sformatf("drain%0d_r_empty", k), {31'b0, r_empty}, (k == 32) ? 1 : 0);
      chk($sformatf("drain%0d_almost_empty", k), {31'b0, almost_empty}, (32 - k <= 4) ? 1 : 0);
      chk($sformatf("drain%0d_r_valid", k), {31'b0, r_valid}, 32'd1);
    end
    chk("drain_rgray", {26'b0, rgray}, 32'h30);
    drive(1'b0, 1'b1, 6'b110000);
    chk("drain_underflow", {31'b0, under_flow}, 32'd1);
    edge_sample();
    chk("drain_refused_rptr", {26'b0, rptr}, 32'd32);
    chk("drain_refused_valid", {31'b0, r_valid}, 32'd0);

    // Reset arriving together with an accepted read.
    reset_with(6'b110000);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 6'b110000);
      edge_sample();
    end
    chk("midread_rptr10", {26'b0, rptr}, 32'd10);
    drive(1'b1, 1'b1, 6'b110000);
    chk("midread_rd_ok", {31'b0, r_empty}, 32'd0);
    edge_sample();
    chk("midread_rptr", {26'b0, rptr}, 32'd0);
    chk("midread_raddr", {27'b0, raddr}, 32'd0);
    chk("midread_r_valid", {31'b0, r_valid}, 32'd0);
    chk("midread_r_empty", {31'b0, r_empty}, 32'd1);
    drive(1'b0, 1'b0, 6'b110000);
    edge_sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
